// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide engine, one bit per cycle, producing the HI/LO pair.
// Signed ops run on operand magnitudes; sign correction is applied once in the FIX state.
// Optional build macro MULDIV_DIVZERO_EN adds the DivZero flag and a short IDLE->FIX path
// for division by zero. HI/LO results are the same either way.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWe,
    input  logic             LoWe,
    input  logic [WIDTH-1:0] WData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
`ifdef MULDIV_DIVZERO_EN
    ,
    output logic             DivZero
`endif
);

`ifdef MULDIV_DIVZERO_EN
    localparam bit DzFast = 1'b1;
`else
    localparam bit DzFast = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;     // product high half / partial remainder
    logic [WIDTH-1:0] sh_q;      // multiplier -> product low half / dividend -> quotient
    logic [WIDTH-1:0] opb_q;     // multiplicand / divisor magnitude
    logic [CNT_W-1:0] cnt_q;
    logic             is_div_q;
    logic             neg_res_q; // negate product or quotient
    logic             neg_rem_q; // negate remainder (dividend was negative)
    logic             dz_q;

    // Operand capture: magnitudes for signed ops, raw values otherwise
    logic             is_signed, sgn_a, sgn_b, start_dz;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        is_signed = ~Op[0];
        sgn_a     = is_signed & A[WIDTH-1];
        sgn_b     = is_signed & B[WIDTH-1];
        mag_a     = sgn_a ? -A : A;
        mag_b     = sgn_b ? -B : B;
        start_dz  = Op[1] & (B == '0);
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide
    logic [WIDTH:0]   mul_sum, div_shr, div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] acc_next, sh_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
        div_shr  = {acc_q, sh_q[WIDTH-1]};
        div_diff = div_shr - {1'b0, opb_q};
        div_ok   = ~div_diff[WIDTH];
        if (is_div_q) begin
            acc_next = div_ok ? div_diff[WIDTH-1:0] : div_shr[WIDTH-1:0];
            sh_next  = {sh_q[WIDTH-2:0], div_ok};
        end else begin
            acc_next = mul_sum[WIDTH:1];
            sh_next  = {mul_sum[0], sh_q[WIDTH-1:1]};
        end
    end

    // Sign correction of the finished magnitude result
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

    always_comb begin
        prod_fix = neg_res_q ? -{acc_q, sh_q} : {acc_q, sh_q};
        // Divide by zero forces an all-ones quotient regardless of sign
        quo_fix  = dz_q ? '1 : (neg_res_q ? -sh_q : sh_q);
        rem_fix  = neg_rem_q ? -acc_q : acc_q;
        fix_hi   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
    end

    // Control FSM with registered Busy/Done and the HI/LO architectural registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= StIdle;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
            acc_q     <= '0;
            sh_q      <= '0;
            opb_q     <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
            DivZero   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (HiWe) Hi <= WData;
                    if (LoWe) Lo <= WData;
                    if (Start) begin
                        // Fast div-by-zero path needs the dividend already in the remainder
                        acc_q     <= (DzFast && start_dz) ? mag_a : '0;
                        sh_q      <= mag_a;
                        opb_q     <= mag_b;
                        cnt_q     <= CNT_W'(WIDTH - 1);
                        is_div_q  <= Op[1];
                        neg_res_q <= sgn_a ^ sgn_b;
                        neg_rem_q <= sgn_a;
                        dz_q      <= start_dz;
                        Busy      <= 1'b1;
                        state_q   <= (DzFast && start_dz) ? StFix : StCalc;
`ifdef MULDIV_DIVZERO_EN
                        DivZero   <= 1'b0;
`endif
                    end
                end
                StCalc: begin
                    acc_q <= acc_next;
                    sh_q  <= sh_next;
                    if (cnt_q == '0) begin
                        state_q <= StFix;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StFix: begin
                    Hi      <= fix_hi;
                    Lo      <= fix_lo;
                    Busy    <= 1'b0;
                    Done    <= 1'b1;
                    state_q <= StDone;
`ifdef MULDIV_DIVZERO_EN
                    DivZero <= dz_q;
`endif
                end
                StDone: begin
                    Done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (default WIDTH=32).
module tb_muldiv_unit;

    localparam int W = 32;

    logic         Clock = 1'b0;
    logic         Reset = 1'b0;
    logic         Start = 1'b0;
    logic [1:0]   Op = 2'b00;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         HiWe = 1'b0;
    logic         LoWe = 1'b0;
    logic [W-1:0] WData = '0;
    logic         Busy, Done;
    logic [W-1:0] Hi, Lo;
`ifdef MULDIV_DIVZERO_EN
    logic         DivZero;
`endif

    muldiv_unit #(.WIDTH(W), .CNT_W(5)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .HiWe(HiWe), .LoWe(LoWe), .WData(WData), .Busy(Busy), .Done(Done),
        .Hi(Hi), .Lo(Lo)
`ifdef MULDIV_DIVZERO_EN
        , .DivZero(DivZero)
`endif
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
        bit           dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model of the arithmetic and latency
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t   e;
        longint sa, sbv, p, q, r;
        logic [63:0] up;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        e.dz  = op[1] && (b == 0);
        e.lat = W + 2;
`ifdef MULDIV_DIVZERO_EN
        if (e.dz) e.lat = 2;
`endif
        case (op)
            2'b00: begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin up = {32'b0, a} * {32'b0, b}; e.hi = up[63:32]; e.lo = up[31:0]; end
            2'b10: begin
                if (b == 0) begin e.hi = a; e.lo = '1; end
                else begin q = sa / sbv; r = sa % sbv; e.hi = r[31:0]; e.lo = q[31:0]; end
            end
            default: begin
                if (b == 0) begin e.hi = a; e.lo = '1; end
                else begin e.hi = a % b; e.lo = a / b; end
            end
        endcase
        return e;
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge Clock);
        Op = op; A = a; B = b; Start = 1'b1;
        sb.push_back(model(op, a, b));
        @(posedge Clock);
        #1 Start = 1'b0;
    endtask

    // Observe one operation up to its Done pulse; optional intrusion at cycle poke_at
    task automatic collect(input int poke_at, output int lat, output int busy_cnt,
                           output bit stable, output bit single, output logic [W-1:0] hi,
                           output logic [W-1:0] lo);
        logic [W-1:0] h0, l0;
        h0 = Hi; l0 = Lo;
        lat = 0; busy_cnt = 0; stable = 1'b1;
        while (lat < 100) begin
            @(negedge Clock);
            lat++;
            if (poke_at != 0 && lat == poke_at) begin
                Start = 1'b1; HiWe = 1'b1; LoWe = 1'b1; WData = 32'hDEAD_BEEF;
                Op = 2'b01; A = 32'h1234_5678; B = 32'h9;
            end else if (poke_at != 0 && lat == poke_at + 1) begin
                Start = 1'b0; HiWe = 1'b0; LoWe = 1'b0;
            end
            if (Done === 1'b1) break;
            if (Busy === 1'b1) busy_cnt++;
            if (Hi !== h0 || Lo !== l0) stable = 1'b0;
        end
        hi = Hi; lo = Lo;
        @(negedge Clock);
        single = (Done === 1'b0);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", Done); end
        checks++; if (Hi !== '0) begin failures++; $display("FAIL reset_hi got=%h exp=0", Hi); end
        checks++; if (Lo !== '0) begin failures++; $display("FAIL reset_lo got=%h exp=0", Lo); end
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic run_table(input string name, input logic [1:0] ops[],
                             input logic [W-1:0] as[], input logic [W-1:0] bs[]);
        int lat, bc; bit st, sg; logic [W-1:0] h, l; exp_t e;
        for (int i = 0; i < ops.size(); i++) begin
            start_op(ops[i], as[i], bs[i]);
            collect(0, lat, bc, st, sg, h, l);
            e = sb.pop_front();
            checks++; if (h !== e.hi) begin failures++; $display("FAIL %s_hi[%0d] got=%h exp=%h", name, i, h, e.hi); end
            checks++; if (l !== e.lo) begin failures++; $display("FAIL %s_lo[%0d] got=%h exp=%h", name, i, l, e.lo); end
            checks++; if (lat !== e.lat) begin failures++; $display("FAIL %s_lat[%0d] got=%0d exp=%0d", name, i, lat, e.lat); end
            checks++; if (bc !== e.lat - 1) begin failures++; $display("FAIL %s_busy[%0d] got=%0d exp=%0d", name, i, bc, e.lat - 1); end
            checks++; if (st !== 1'b1) begin failures++; $display("FAIL %s_stable[%0d] got=%b exp=1", name, i, st); end
            checks++; if (sg !== 1'b1) begin failures++; $display("FAIL %s_pulse[%0d] got=%b exp=1", name, i, sg); end
`ifdef MULDIV_DIVZERO_EN
            checks++; if (DivZero !== e.dz) begin failures++; $display("FAIL %s_divzero[%0d] got=%b exp=%b", name, i, DivZero, e.dz); end
`endif
        end
    endtask

    task automatic test_mul();
        logic [1:0] ops[] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
        logic [W-1:0] as[] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, $urandom, $urandom};
        logic [W-1:0] bs[] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, $urandom, $urandom};
        run_table("mul", ops, as, bs);
    endtask

    task automatic test_div();
        logic [1:0] ops[] = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10};
        logic [W-1:0] as[] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd7, $urandom, $urandom};
        logic [W-1:0] bs[] = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                               $urandom_range(1, 32'hFFFF), 32'hFFFF_FF00 | $urandom_range(1, 255)};
        run_table("div", ops, as, bs);
    endtask

    task automatic test_divzero();
        logic [1:0] ops[] = '{2'b11, 2'b10, 2'b01};
        logic [W-1:0] as[] = '{32'd5, 32'hFFFF_FFFB, 32'd6};
        logic [W-1:0] bs[] = '{32'd0, 32'd0, 32'd3};
        run_table("dz", ops, as, bs);
    endtask

    task automatic test_direct_write();
        int lat, bc; bit st, sg; logic [W-1:0] h, l; exp_t e;
        @(negedge Clock); HiWe = 1'b1; WData = 32'hCAFE_0001;
        @(posedge Clock); #1 HiWe = 1'b0;
        checks++; if (Hi !== 32'hCAFE_0001) begin failures++; $display("FAIL mthi got=%h exp=cafe0001", Hi); end
        @(negedge Clock); LoWe = 1'b1; WData = 32'hCAFE_0002;
        @(posedge Clock); #1 LoWe = 1'b0;
        checks++; if (Lo !== 32'hCAFE_0002) begin failures++; $display("FAIL mtlo got=%h exp=cafe0002", Lo); end
        // Write plus Start in the same idle cycle: write lands, result overwrites later
        @(negedge Clock);
        HiWe = 1'b1; LoWe = 1'b1; WData = 32'h0BAD_F00D; Start = 1'b1;
        Op = 2'b11; A = 32'd1000; B = 32'd33;
        sb.push_back(model(2'b11, 32'd1000, 32'd33));
        @(posedge Clock); #1 HiWe = 1'b0; LoWe = 1'b0; Start = 1'b0;
        checks++; if (Hi !== 32'h0BAD_F00D || Lo !== 32'h0BAD_F00D) begin failures++; $display("FAIL wr_start_write got=%h/%h exp=0badf00d", Hi, Lo); end
        collect(0, lat, bc, st, sg, h, l);
        e = sb.pop_front();
        checks++; if (h !== e.hi || l !== e.lo) begin failures++; $display("FAIL wr_start_result got=%h/%h exp=%h/%h", h, l, e.hi, e.lo); end
    endtask

    task automatic test_ignore();
        int lat, bc; bit st, sg; logic [W-1:0] h, l; exp_t e;
        start_op(2'b00, 32'hFFFF_FF00, 32'h0001_0003);
        collect(10, lat, bc, st, sg, h, l);
        e = sb.pop_front();
        checks++; if (h !== e.hi || l !== e.lo) begin failures++; $display("FAIL ign_result got=%h/%h exp=%h/%h", h, l, e.hi, e.lo); end
        checks++; if (lat !== W + 2) begin failures++; $display("FAIL ign_lat got=%0d exp=%0d", lat, W + 2); end
        checks++; if (bc !== W + 1) begin failures++; $display("FAIL ign_busy got=%0d exp=%0d", bc, W + 1); end
        checks++; if (st !== 1'b1) begin failures++; $display("FAIL ign_stable got=%b exp=1", st); end
        bc = 0;
        repeat (40) begin @(negedge Clock); if (Done === 1'b1 || Busy === 1'b1) bc++; end
        checks++; if (bc !== 0) begin failures++; $display("FAIL ign_no_second got=%0d exp=0", bc); end
    endtask

    task automatic test_reset_mid();
        int lat, bc; bit st, sg; logic [W-1:0] h, l; exp_t e;
        start_op(2'b01, 32'h7777_7777, 32'h3333_3333);
        repeat (10) @(negedge Clock);
        #2 Reset = 1'b0;
        #1;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", Busy); end
        checks++; if (Hi !== '0 || Lo !== '0) begin failures++; $display("FAIL rst_mid_hilo got=%h/%h exp=0/0", Hi, Lo); end
        void'(sb.pop_front());
        bc = 0;
        repeat (3) begin @(negedge Clock); if (Done === 1'b1) bc++; end
        Reset = 1'b1;
        repeat (40) begin @(negedge Clock); if (Done === 1'b1) bc++; end
        checks++; if (bc !== 0) begin failures++; $display("FAIL rst_mid_nodone got=%0d exp=0", bc); end
        start_op(2'b10, 32'hFFFF_FF9C, 32'd9);
        collect(0, lat, bc, st, sg, h, l);
        e = sb.pop_front();
        checks++; if (h !== e.hi || l !== e.lo) begin failures++; $display("FAIL rst_mid_next got=%h/%h exp=%h/%h", h, l, e.hi, e.lo); end
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL rst_mid_lat got=%0d exp=%0d", lat, e.lat); end
    endtask

    task automatic test_back_to_back();
        int lat, bc, n; bit st, sg; logic [W-1:0] h, l, hd; exp_t e;
        start_op(2'b11, 32'd1000, 32'd9);
        n = 0;
        do begin @(negedge Clock); n++; end while (Done !== 1'b1 && n < 100);
        e = sb.pop_front();
        checks++; if (Done !== 1'b1 || Hi !== e.hi || Lo !== e.lo) begin failures++; $display("FAIL b2b_first got=%b %h/%h exp=1 %h/%h", Done, Hi, Lo, e.hi, e.lo); end
        hd = Hi;
        // Start during the Done cycle must be dropped
        Start = 1'b1; Op = 2'b01; A = 32'd3; B = 32'd3;
        @(posedge Clock); #1 Start = 1'b0;
        @(negedge Clock);
        checks++; if (Busy !== 1'b0 || Hi !== hd) begin failures++; $display("FAIL b2b_start_in_done got=%b %h exp=0 %h", Busy, Hi, hd); end
        for (int i = 0; i < 3; i++) begin
            start_op(2'(i), $urandom, $urandom_range(1, 1000));
            collect(0, lat, bc, st, sg, h, l);
            e = sb.pop_front();
            checks++; if (h !== e.hi || l !== e.lo) begin failures++; $display("FAIL b2b_result[%0d] got=%h/%h exp=%h/%h", i, h, l, e.hi, e.lo); end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_divzero();
        test_direct_write();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
